dense_result_tx: RTL and testbench
==================================

DENSE_RESULT_TX -- requirements
Module: dense_result_tx

Interface
REQ-001 SHALL have parameter BIAS, default 32: number of result words (neurons) per frame; BIAS >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width; words are IEEE-754 single precision.
REQ-003 SHALL have port clk  input  1: the one clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port start_i  input  1: single-cycle request to capture result_i.
REQ-006 SHALL have port result_i  input  BIAS*DATA_WIDTH: parallel dense-layer results; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port busy_o  output  1: frame captured and not yet fully sent.
REQ-008 SHALL have port valid_o  output  1: data_o holds a word to transmit.
REQ-009 SHALL have port ready_i  input  1: downstream accepts the word on this edge.
REQ-010 SHALL have port data_o  output  DATA_WIDTH: current word.
REQ-011 SHALL have port index_o  output  $clog2(BIAS): index of the current word.
REQ-012 SHALL have port last_o  output  1: current word is index BIAS-1.
REQ-013 SHALL have port done_o  output  1: one-cycle pulse after the final handshake.

Function
REQ-014 SHALL implement two states: IDLE and SEND.
REQ-015 In IDLE, start_i=1 SHALL latch all of result_i into an internal frame register, clear the word counter and enter SEND on the same edge.
REQ-016 In SEND, valid_o SHALL be 1, busy_o SHALL be 1, data_o SHALL equal frame word[counter], index_o SHALL equal the counter, and last_o SHALL equal (counter == BIAS-1); all outputs SHALL be registered or derived only from registered state.
REQ-017 The first word SHALL be valid in the cycle after the edge at which start_i is sampled (latency 1).
REQ-018 A handshake SHALL occur on an edge where valid_o=1 and ready_i=1; the counter SHALL then advance by 1.
REQ-019 While valid_o=1 and ready_i=0, data_o, index_o and last_o SHALL hold stable, and valid_o SHALL stay 1.
REQ-020 A handshake with last_o=1 SHALL return the block to IDLE, drop valid_o and busy_o, and assert done_o for exactly the next cycle.
REQ-021 start_i while busy_o=1 SHALL be ignored, with no effect on the frame, counter or outputs; changes to result_i after capture SHALL not affect the transmission.
REQ-022 start_i in the cycle where done_o=1 SHALL be accepted, giving back-to-back frames with one idle cycle between them.
REQ-023 With ready_i held at 1, a frame SHALL take exactly BIAS consecutive cycles of valid_o.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, counter=0, valid_o=0, busy_o=0, last_o=0, done_o=0, data_o=0 and index_o=0.
REQ-025 Reset during SEND SHALL abort the frame; no done_o is produced, and a new start_i after release SHALL begin at index 0.
REQ-026 The frame register need not be reset, but data_o SHALL read 0 while the block is in IDLE.

Configuration
REQ-027 Macro DENSE_RESULT_TX_ARGMAX_EN, when defined, SHALL add the following outputs:
  - max_idx_o  output  $clog2(BIAS): index of the largest word in the last completed frame.
  - max_val_o  output  DATA_WIDTH: value of that word.
  Both SHALL be updated incrementally at each handshake and SHALL be valid from the cycle done_o=1 until the next start_i is accepted.
REQ-028 Argmax comparison rules:
  - Comparison SHALL use IEEE sign-magnitude ordering on raw bits.
  - +0 and -0 SHALL be treated as equal.
  - On ties, the lower index SHALL be kept.
  - NaN SHALL be ordered by raw magnitude with no special handling.
  - Reset SHALL set max_idx_o=0 and max_val_o=0.
REQ-029 Without DENSE_RESULT_TX_ARGMAX_EN, the ports SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover the following directed scenarios (the first five use BIAS=4, DATA_WIDTH=32):
  - Basic frame: result_i = {40800000,40400000,40000000,3F800000}, start_i pulse, ready_i=1 -> data_o = 3F800000, 40000000, 40400000, 40800000 on 4 consecutive cycles; last_o only on the 4th; done_o one cycle later.
  - Backpressure: ready_i=0 for 3 cycles at index 1 -> data_o holds 40000000, index_o holds 1 for all 3 cycles; the frame completes with no loss or duplication.
  - Busy start: start_i plus a new result_i during SEND -> the original words are sent unchanged.
  - Reset mid-frame: rst_n low at index 2 -> valid_o, busy_o and data_o are 0 immediately; the next start_i begins at index 0.
  - Argmax (macro defined): words {C0000000, 40A00000, 40A00000, 3F800000} -> max_idx_o=1, max_val_o=40A00000 at done_o.
  - Back-to-back: default parameters, start_i during done_o -> the second frame's first valid occurs exactly 2 cycles after the first frame's last handshake.

Source files
------------

// File: rtl/dense_result_tx.sv
// ---------------------------------------------------------------------------
// dense_result_tx
//
// Captures a full frame of dense-layer results in one cycle, then streams the
// frame out one IEEE-754 word at a time over a valid/ready handshake. Word 0
// goes first and word BIAS-1 last. A one-cycle done_o pulse follows the final
// handshake.
//
// Parameters
//   BIAS        number of result words (neurons) per frame, BIAS >= 2
//   DATA_WIDTH  word width (IEEE-754 single precision)
//
// Ports
//   clk        in   the one clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start_i    in   single-cycle request to capture result_i (ignored while busy)
//   result_i   in   BIAS*DATA_WIDTH parallel results, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   busy_o     out  frame captured and not yet fully sent
//   valid_o    out  data_o holds a word to transmit
//   ready_i    in   downstream accepts the word on this edge
//   data_o     out  current word (0 while idle)
//   index_o    out  index of the current word
//   last_o     out  current word is index BIAS-1
//   done_o     out  one-cycle pulse after the final handshake
//
// Optional feature (macro DENSE_RESULT_TX_ARGMAX_EN)
//   max_idx_o  out  index of the largest word in the last completed frame
//   max_val_o  out  value of that word
// ---------------------------------------------------------------------------
module dense_result_tx #(
   parameter int BIAS       = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start_i,
   input  logic [BIAS*DATA_WIDTH-1:0] result_i,
   output logic                       busy_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [DATA_WIDTH-1:0]      data_o,
   output logic [$clog2(BIAS)-1:0]    index_o,
   output logic                       last_o,
   output logic                       done_o
`ifdef DENSE_RESULT_TX_ARGMAX_EN
   ,
   output logic [$clog2(BIAS)-1:0]    max_idx_o,
   output logic [DATA_WIDTH-1:0]      max_val_o
`endif
);

   localparam int IDX_W = $clog2(BIAS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BIAS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [IDX_W-1:0]      cnt_q;
   logic [IDX_W-1:0]      cnt_d;
   logic                  done_q;
   logic                  done_d;
   logic [DATA_WIDTH-1:0] frame_q [BIAS];
   logic                  capture;
   logic                  handshake;

   assign capture   = (state_q == IDLE) && start_i;
   assign handshake = (state_q == SEND) && ready_i;

   // Next-state logic. A start request is only honoured in IDLE, which also
   // covers the done_o cycle, so frames can run back to back with one idle
   // cycle in between. The counter returns to 0 after the last word so that
   // index_o reads 0 whenever the block is idle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = SEND;
               cnt_d   = '0;
            end
         end
         SEND: begin
            if (ready_i) begin
               if (cnt_q == LAST_IDX) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Control state register. Reset aborts any frame in flight and suppresses
   // the done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Frame storage. It is deliberately left out of reset: its contents are
   // only observable while sending, and data_o is forced to 0 when idle.
   // Capturing only on an accepted start keeps later result_i changes from
   // disturbing a frame in flight.
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int k = 0; k < BIAS; k++) begin
            frame_q[k] <= result_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // All outputs are decoded from registered state only, so nothing on the
   // downstream side sees a combinational path from ready_i or start_i.
   assign valid_o = (state_q == SEND);
   assign busy_o  = (state_q == SEND);
   assign index_o = cnt_q;
   assign last_o  = (state_q == SEND) && (cnt_q == LAST_IDX);
   assign done_o  = done_q;
   assign data_o  = (state_q == SEND) ? frame_q[cnt_q] : '0;

`ifdef DENSE_RESULT_TX_ARGMAX_EN

   logic [IDX_W-1:0]      max_idx_q;
   logic [DATA_WIDTH-1:0] max_val_q;

   // Maps a float's raw bits to an unsigned key whose natural ordering is the
   // IEEE sign-magnitude ordering: positives sit above negatives, negatives
   // have their magnitude inverted so larger magnitude sorts lower, and both
   // zeros share one key. NaNs fall wherever their raw magnitude puts them.
   function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] w);
      logic [DATA_WIDTH-2:0] mag;
      mag = w[DATA_WIDTH-2:0];
      if (mag == '0) begin
         return {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else if (w[DATA_WIDTH-1]) begin
         return {1'b0, ~mag};
      end else begin
         return {1'b1, mag};
      end
   endfunction

   // Running argmax, updated at each handshake. Word 0 seeds the search and
   // a strict greater-than keeps the lower index on ties. After the final
   // handshake the result holds until the next frame's first handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_idx_q <= '0;
         max_val_q <= '0;
      end else if (handshake) begin
         if ((cnt_q == '0) || (order_key(data_o) > order_key(max_val_q))) begin
            max_idx_q <= cnt_q;
            max_val_q <= data_o;
         end
      end
   end

   assign max_idx_o = max_idx_q;
   assign max_val_o = max_val_q;

`endif

endmodule

// File: tb/tb_dense_result_tx.sv
// ---------------------------------------------------------------------------
// tb_dense_result_tx
//
// Drives two instances of dense_result_tx: a small one (BIAS=4) for the
// directed frame scenarios and randomized traffic, and a default-parameter
// one (BIAS=32) for back-to-back frames and randomized traffic. Each instance
// is shadowed by a queue-based model: an accepted start loads the whole frame
// into a queue, each handshake pops the front, and emptying the queue raises
// the done pulse. Compile with +define+DENSE_RESULT_TX_ARGMAX_EN to exercise
// the argmax outputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dense_result_tx;

   localparam int SB = 4;
   localparam int BB = 32;
   localparam int DW = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   logic             s_start  = 1'b0;
   logic             s_ready  = 1'b0;
   logic [SB*DW-1:0] s_result = '0;
   logic             s_busy;
   logic             s_valid;
   logic [DW-1:0]    s_data;
   logic [1:0]       s_index;
   logic             s_last;
   logic             s_done;

   logic             b_start  = 1'b0;
   logic             b_ready  = 1'b0;
   logic [BB*DW-1:0] b_result = '0;
   logic             b_busy;
   logic             b_valid;
   logic [DW-1:0]    b_data;
   logic [4:0]       b_index;
   logic             b_last;
   logic             b_done;

`ifdef DENSE_RESULT_TX_ARGMAX_EN
   logic [1:0]       s_max_idx;
   logic [DW-1:0]    s_max_val;
   logic [4:0]       b_max_idx;
   logic [DW-1:0]    b_max_val;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0] sq [$];
   logic [DW-1:0] bq [$];
   bit            sm_done = 1'b0;
   bit            bm_done = 1'b0;
   int            sm_argidx = 0;
   logic [DW-1:0] sm_argval = '0;
   int            bm_argidx = 0;
   logic [DW-1:0] bm_argval = '0;

   dense_result_tx #(.BIAS(SB), .DATA_WIDTH(DW)) u_small (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (s_start),
      .result_i  (s_result),
      .busy_o    (s_busy),
      .valid_o   (s_valid),
      .ready_i   (s_ready),
      .data_o    (s_data),
      .index_o   (s_index),
      .last_o    (s_last),
      .done_o    (s_done)
`ifdef DENSE_RESULT_TX_ARGMAX_EN
      ,
      .max_idx_o (s_max_idx),
      .max_val_o (s_max_val)
`endif
   );

   dense_result_tx u_big (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (b_start),
      .result_i  (b_result),
      .busy_o    (b_busy),
      .valid_o   (b_valid),
      .ready_i   (b_ready),
      .data_o    (b_data),
      .index_o   (b_index),
      .last_o    (b_last),
      .done_o    (b_done)
`ifdef DENSE_RESULT_TX_ARGMAX_EN
      ,
      .max_idx_o (b_max_idx),
      .max_val_o (b_max_val)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      forever #5 clk = ~clk;
   end

   // One comparison: counts it, reports it when the values disagree.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives the small instance's controls on a falling edge, waits for the
   // rising edge that samples them, then settles just past it.
   task automatic applyStimulus(input logic st, input logic rdy);
      @(negedge clk);
      s_start = st;
      s_ready = rdy;
      @(posedge clk);
      #2;
   endtask

   // Same as applyStimulus, for the default-parameter instance.
   task automatic applyBig(input logic st, input logic rdy);
      @(negedge clk);
      b_start = st;
      b_ready = rdy;
      @(posedge clk);
      #2;
   endtask

   // Stimulus word generator biased towards the interesting float values.
   function automatic logic [DW-1:0] randWord();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'h7FC0_0000;
         3:       return 32'hFFC0_0000;
         4:       return 32'h40A0_0000;
         default: return $urandom;
      endcase
   endfunction

   // True when float a is strictly greater than float b, written as a case
   // split on signs: both zeros are equal, a positive beats a negative, two
   // positives compare by magnitude, two negatives by reversed magnitude.
   function automatic bit fbetter(input logic [DW-1:0] a, input logic [DW-1:0] b);
      bit az;
      bit bz;
      bit an;
      bit bn;
      az = (a[30:0] == 31'd0);
      bz = (b[30:0] == 31'd0);
      if (az && bz) return 1'b0;
      an = a[31] && !az;
      bn = b[31] && !bz;
      if (an != bn) return bn;
      if (!an) return a[30:0] > b[30:0];
      return a[30:0] < b[30:0];
   endfunction

   // Reference model of the small instance.
   always @(posedge clk or negedge rst_n) begin
      logic [DW-1:0] tmp;
      if (!rst_n) begin
         sq.delete();
         sm_done = 1'b0;
      end else begin
         sm_done = 1'b0;
         if (sq.size() != 0) begin
            if (s_ready) begin
               tmp = sq.pop_front();
               if (sq.size() == 0) sm_done = 1'b1;
            end
         end else if (s_start) begin
            for (int k = 0; k < SB; k++) sq.push_back(s_result[k*DW +: DW]);
            sm_argidx = 0;
            for (int k = 1; k < SB; k++) begin
               if (fbetter(sq[k], sq[sm_argidx])) sm_argidx = k;
            end
            sm_argval = sq[sm_argidx];
         end
      end
   end

   // Reference model of the default-parameter instance.
   always @(posedge clk or negedge rst_n) begin
      logic [DW-1:0] tmp;
      if (!rst_n) begin
         bq.delete();
         bm_done = 1'b0;
      end else begin
         bm_done = 1'b0;
         if (bq.size() != 0) begin
            if (b_ready) begin
               tmp = bq.pop_front();
               if (bq.size() == 0) bm_done = 1'b1;
            end
         end else if (b_start) begin
            for (int k = 0; k < BB; k++) bq.push_back(b_result[k*DW +: DW]);
            bm_argidx = 0;
            for (int k = 1; k < BB; k++) begin
               if (fbetter(bq[k], bq[bm_argidx])) bm_argidx = k;
            end
            bm_argval = bq[bm_argidx];
         end
      end
   end

   // Every falling edge: both instances against their models.
   always @(negedge clk) begin
      checkOutput("s_valid", {31'd0, s_valid}, {31'd0, sq.size() != 0});
      checkOutput("s_busy",  {31'd0, s_busy},  {31'd0, sq.size() != 0});
      checkOutput("s_data",  s_data, (sq.size() != 0) ? sq[0] : 32'd0);
      checkOutput("s_index", {30'd0, s_index}, (sq.size() != 0) ? SB - sq.size() : 0);
      checkOutput("s_last",  {31'd0, s_last},  {31'd0, sq.size() == 1});
      checkOutput("s_done",  {31'd0, s_done},  {31'd0, sm_done});
      checkOutput("b_valid", {31'd0, b_valid}, {31'd0, bq.size() != 0});
      checkOutput("b_busy",  {31'd0, b_busy},  {31'd0, bq.size() != 0});
      checkOutput("b_data",  b_data, (bq.size() != 0) ? bq[0] : 32'd0);
      checkOutput("b_index", {27'd0, b_index}, (bq.size() != 0) ? BB - bq.size() : 0);
      checkOutput("b_last",  {31'd0, b_last},  {31'd0, bq.size() == 1});
      checkOutput("b_done",  {31'd0, b_done},  {31'd0, bm_done});
`ifdef DENSE_RESULT_TX_ARGMAX_EN
      if (sm_done) begin
         checkOutput("s_max_idx", {30'd0, s_max_idx}, sm_argidx);
         checkOutput("s_max_val", s_max_val, sm_argval);
      end
      if (bm_done) begin
         checkOutput("b_max_idx", {27'd0, b_max_idx}, bm_argidx);
         checkOutput("b_max_val", b_max_val, bm_argval);
      end
`endif
   end

   // Directed scenarios followed by randomized traffic on both instances.
   initial begin
      logic [SB*DW-1:0] r0;
      r0 = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};

      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_valid", {31'd0, s_valid}, 32'd0);
      checkOutput("rst_data",  s_data, 32'd0);
      #20 rst_n = 1'b1;

      $display("[TB] basic frame");
      s_result = r0;
      applyStimulus(1'b1, 1'b1);
      checkOutput("basic_w0",   s_data, 32'h3F80_0000);
      checkOutput("basic_i0",   {30'd0, s_index}, 32'd0);
      checkOutput("basic_l0",   {31'd0, s_last}, 32'd0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("basic_w1",   s_data, 32'h4000_0000);
      applyStimulus(1'b0, 1'b1);
      checkOutput("basic_w2",   s_data, 32'h4040_0000);
      checkOutput("basic_l2",   {31'd0, s_last}, 32'd0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("basic_w3",   s_data, 32'h4080_0000);
      checkOutput("basic_l3",   {31'd0, s_last}, 32'd1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("basic_done", {31'd0, s_done}, 32'd1);
      checkOutput("basic_idle", {31'd0, s_valid}, 32'd0);
`ifdef DENSE_RESULT_TX_ARGMAX_EN
      checkOutput("basic_maxi", {30'd0, s_max_idx}, 32'd3);
      checkOutput("basic_maxv", s_max_val, 32'h4080_0000);
`endif
      applyStimulus(1'b0, 1'b1);
      checkOutput("basic_pulse", {31'd0, s_done}, 32'd0);

      $display("[TB] backpressure");
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0);
         checkOutput("bp_data",  s_data, 32'h4000_0000);
         checkOutput("bp_index", {30'd0, s_index}, 32'd1);
         checkOutput("bp_valid", {31'd0, s_valid}, 32'd1);
      end
      applyStimulus(1'b0, 1'b1);
      checkOutput("bp_w2", s_data, 32'h4040_0000);
      applyStimulus(1'b0, 1'b1);
      checkOutput("bp_w3", s_data, 32'h4080_0000);
      applyStimulus(1'b0, 1'b1);
      checkOutput("bp_done", {31'd0, s_done}, 32'd1);
      applyStimulus(1'b0, 1'b1);

      $display("[TB] start while busy");
      applyStimulus(1'b1, 1'b1);
      s_result = {SB{32'hDEAD_BEEF}};
      applyStimulus(1'b1, 1'b1);
      checkOutput("busy_w1", s_data, 32'h4000_0000);
      applyStimulus(1'b1, 1'b1);
      checkOutput("busy_w2", s_data, 32'h4040_0000);
      applyStimulus(1'b0, 1'b1);
      checkOutput("busy_w3", s_data, 32'h4080_0000);
      applyStimulus(1'b0, 1'b1);
      checkOutput("busy_done", {31'd0, s_done}, 32'd1);
      s_result = r0;
      applyStimulus(1'b0, 1'b1);

      $display("[TB] reset mid-frame");
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("rmf_idx2", {30'd0, s_index}, 32'd2);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rmf_valid", {31'd0, s_valid}, 32'd0);
      checkOutput("rmf_busy",  {31'd0, s_busy},  32'd0);
      checkOutput("rmf_data",  s_data, 32'd0);
      checkOutput("rmf_index", {30'd0, s_index}, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      applyStimulus(1'b0, 1'b1);
      checkOutput("rmf_nodone", {31'd0, s_done}, 32'd0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("rmf_restart_i", {30'd0, s_index}, 32'd0);
      checkOutput("rmf_restart_d", s_data, 32'h3F80_0000);
      repeat (4) applyStimulus(1'b0, 1'b1);
      checkOutput("rmf_done", {31'd0, s_done}, 32'd1);

`ifdef DENSE_RESULT_TX_ARGMAX_EN
      $display("[TB] argmax");
      s_result = {32'hC000_0000, 32'h40A0_0000, 32'h40A0_0000, 32'h3F80_0000};
      applyStimulus(1'b1, 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b1);
      checkOutput("am_done", {31'd0, s_done}, 32'd1);
      checkOutput("am_idx",  {30'd0, s_max_idx}, 32'd1);
      checkOutput("am_val",  s_max_val, 32'h40A0_0000);
`endif
      applyStimulus(1'b0, 1'b0);

      $display("[TB] back-to-back, BIAS=32");
      for (int k = 0; k < BB; k++) b_result[k*DW +: DW] = $urandom;
      applyBig(1'b1, 1'b1);
      checkOutput("b2b_first", {27'd0, b_index}, 32'd0);
      repeat (BB - 1) applyBig(1'b0, 1'b1);
      checkOutput("b2b_last", {31'd0, b_last}, 32'd1);
      checkOutput("b2b_lidx", {27'd0, b_index}, 32'd31);
      applyBig(1'b0, 1'b1);
      checkOutput("b2b_done",  {31'd0, b_done},  32'd1);
      checkOutput("b2b_gap",   {31'd0, b_valid}, 32'd0);
      applyBig(1'b1, 1'b1);
      checkOutput("b2b_valid", {31'd0, b_valid}, 32'd1);
      checkOutput("b2b_idx0",  {27'd0, b_index}, 32'd0);
      checkOutput("b2b_word0", b_data, b_result[31:0]);
      repeat (BB) applyBig(1'b0, 1'b1);
      checkOutput("b2b_done2", {31'd0, b_done}, 32'd1);

      $display("[TB] random traffic, BIAS=4");
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < SB; k++) s_result[k*DW +: DW] = randWord();
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      end

      $display("[TB] random traffic, BIAS=32");
      for (int n = 0; n < 300; n++) begin
         for (int k = 0; k < BB; k++) b_result[k*DW +: DW] = randWord();
         applyBig($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      end

      applyStimulus(1'b0, 1'b0);
      applyBig(1'b0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Guards against a stuck run.
   initial begin
      #500000;
      miscompares++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
